// File: rtl/clock_gate_pkg.sv
// Shared helpers for the clock gate: only a constant ceil(log2) function.
package clock_gate_pkg;

  // Number of bits needed to index 'value' distinct states (ceil(log2(value))).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(value)) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/icg_cell.sv
// Latch-based integrated clock gate. Kept in its own module so it can be
// replaced by a library ICG cell without touching the control logic.
module icg_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic gclk
);

  logic en_latched;

  // Transparent while clk is low, holds while clk is high; reset closes the gate at once.
  always_latch begin
    if (rst) begin
      en_latched <= 1'b0;
    end else if (!clk) begin
      en_latched <= en;
    end
  end

  // Latch output is stable across the high phase, so the AND cannot glitch or truncate.
  assign gclk = clk & en_latched;

endmodule

// File: rtl/clock_gate.sv
// Clock gate with optional hold-off, registered gate status and an active-cycle counter.
// All state lives in the free-running clk domain; nothing is clocked by gclk.
module clock_gate
  import clock_gate_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             test_en,
  input  logic             clr_cnt,
  output logic             gclk,
  output logic             clk_on,
  output logic [CNT_W-1:0] active_cycles
);

  localparam int unsigned HoldBits = clog2(HOLD_CYCLES + 1);
  localparam int unsigned HoldW    = (HoldBits < 1) ? 1 : HoldBits;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES);

  logic             req;
  logic [HoldW-1:0] hold_cnt_d, hold_cnt_q;
  logic             clk_on_d, clk_on_q;
  logic [CNT_W-1:0] active_d, active_q;

  assign req = enable | test_en | (hold_cnt_q != '0);

  icg_cell u_icg (
    .clk  (clk),
    .rst  (rst),
    .en   (req),
    .gclk (gclk)
  );

  // Next-state for hold counter, gate status and active-cycle counter.
  // req sampled at the rising edge equals what the latch captured in the preceding
  // low phase, because the latch is transparent right up to that edge.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    clk_on_d   = req;
    active_d   = active_q;

    if (enable | test_en) begin
      hold_cnt_d = HoldLoad;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HoldW'(1);
    end

    if (clr_cnt) begin
      active_d = '0;
    end else if (req && (active_q != '1)) begin
      active_d = active_q + CNT_W'(1);
    end
  end

  // State registers, asynchronously cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      clk_on_q   <= 1'b0;
      active_q   <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      clk_on_q   <= clk_on_d;
      active_q   <= active_d;
    end
  end

  assign clk_on        = clk_on_q;
  assign active_cycles = active_q;

endmodule

// File: tb/tb_clock_gate.sv
// Directed self-checking bench for clock_gate: three instances cover HOLD_CYCLES=0,
// HOLD_CYCLES=4 and a 4-bit counter.
module tb_clock_gate;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance 0: HOLD_CYCLES=0, CNT_W=32
  logic        en0 = 1'b0, tst0 = 1'b0, clr0 = 1'b0;
  logic        gclk0, clk_on0;
  logic [31:0] active0;
  // Instance 4: HOLD_CYCLES=4, CNT_W=32
  logic        en4 = 1'b0, tst4 = 1'b0, clr4 = 1'b0;
  logic        gclk4, clk_on4;
  logic [31:0] active4;
  // Instance c: HOLD_CYCLES=0, CNT_W=4
  logic        enc = 1'b0, tstc = 1'b0, clrc = 1'b0;
  logic        gclkc, clk_onc;
  logic [3:0]  activec;

  int checks = 0;
  int errors = 0;
  int p0 = 0;
  int p4 = 0;
  int base0;
  int base4;

  always #5 clk = ~clk;

  always @(posedge gclk0) p0++;
  always @(posedge gclk4) p4++;

  clock_gate #(.HOLD_CYCLES(0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .enable(en0), .test_en(tst0), .clr_cnt(clr0),
    .gclk(gclk0), .clk_on(clk_on0), .active_cycles(active0)
  );

  clock_gate #(.HOLD_CYCLES(4), .CNT_W(32)) dut4 (
    .clk(clk), .rst(rst), .enable(en4), .test_en(tst4), .clr_cnt(clr4),
    .gclk(gclk4), .clk_on(clk_on4), .active_cycles(active4)
  );

  clock_gate #(.HOLD_CYCLES(0), .CNT_W(4)) dutc (
    .clk(clk), .rst(rst), .enable(enc), .test_en(tstc), .clr_cnt(clrc),
    .gclk(gclkc), .clk_on(clk_onc), .active_cycles(activec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_gclk0", 32'(gclk0), 32'd0);
    chk("rst_clk_on0", 32'(clk_on0), 32'd0);
    chk("rst_active0", active0, 32'd0);
    chk("rst_activec", 32'(activec), 32'd0);

    // Release reset in a high phase: no gclk edge in that phase
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rel_gclk0", 32'(gclk0), 32'd0);

    // HOLD=0: enable for 3 edges -> 3 pulses
    @(negedge clk); #1;
    base0 = p0;
    en0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("en3_gclk", 32'(gclk0), 32'd1);
      chk("en3_clk_on", 32'(clk_on0), 32'd1);
    end
    en0 = 1'b0;  // dropped while clk high: still gated through this phase
    @(posedge clk); #1;
    chk("en3_off_gclk", 32'(gclk0), 32'd0);
    chk("en3_off_clk_on", 32'(clk_on0), 32'd0);
    chk("en3_pulses", 32'(p0 - base0), 32'd3);
    chk("en3_active", active0, 32'd3);

    // Glitch rejection: toggling enable while clk high with gate closed
    en0 = 1'b1; #1;
    chk("glitch_rise", 32'(gclk0), 32'd0);
    en0 = 1'b0; #1;
    chk("glitch_fall", 32'(gclk0), 32'd0);
    @(posedge clk); #1;
    chk("glitch_next_edge", 32'(gclk0), 32'd0);
    chk("glitch_pulses", 32'(p0 - base0), 32'd3);

    // Dropping enable mid-pulse must not truncate the high phase
    @(negedge clk); #1;
    en0 = 1'b1;
    @(posedge clk); #1;
    chk("trunc_open", 32'(gclk0), 32'd1);
    en0 = 1'b0; #1;
    chk("trunc_hold", 32'(gclk0), 32'd1);
    @(negedge clk); #1;
    chk("trunc_low", 32'(gclk0), 32'd0);
    @(posedge clk); #1;
    chk("trunc_closed", 32'(gclk0), 32'd0);
    chk("trunc_pulses", 32'(p0 - base0), 32'd4);
    chk("trunc_active", active0, 32'd4);

    // Clear counter with gate closed
    @(negedge clk); #1;
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    chk("clr_active0", active0, 32'd0);

    // test_en for 10 cycles -> gclk follows clk
    @(negedge clk); #1;
    base0 = p0;
    tst0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("tst_high", 32'(gclk0), 32'd1);
      if (i == 9) tst0 = 1'b0;
      @(negedge clk); #1;
      chk("tst_low", 32'(gclk0), 32'd0);
    end
    @(posedge clk); #1;
    chk("tst_after", 32'(gclk0), 32'd0);
    chk("tst_pulses", 32'(p0 - base0), 32'd10);
    chk("tst_active", active0, 32'd10);

    // CNT_W=4 saturation, then clear beats increment
    @(negedge clk); #1;
    enc = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("sat_active", 32'(activec), 32'd15);
    chk("sat_clk_on", 32'(clk_onc), 32'd1);
    clrc = 1'b1;
    @(posedge clk); #1;
    chk("sat_clr", 32'(activec), 32'd0);
    clrc = 1'b0;
    @(posedge clk); #1;
    chk("sat_after_clr", 32'(activec), 32'd1);
    enc = 1'b0;

    // HOLD=4: single-cycle enable -> 5 pulses
    @(negedge clk); #1;
    base4 = p4;
    en4 = 1'b1;
    @(posedge clk); #1;
    en4 = 1'b0;
    chk("hold_first", 32'(gclk4), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_last", 32'(gclk4), 32'd1);
    @(posedge clk); #1;
    chk("hold_closed", 32'(gclk4), 32'd0);
    chk("hold_clk_on", 32'(clk_on4), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_pulses", 32'(p4 - base4), 32'd5);
    chk("hold_active", active4, 32'd5);

    // Reset mid-run while gclk high; hold count on dut4 discarded
    @(negedge clk); #1;
    en0 = 1'b1;
    en4 = 1'b1;
    @(posedge clk); #1;
    en4 = 1'b0;
    chk("mid_gclk_high", 32'(gclk0), 32'd1);
    rst = 1'b1; #1;
    chk("mid_gclk0", 32'(gclk0), 32'd0);
    chk("mid_gclk4", 32'(gclk4), 32'd0);
    chk("mid_clk_on0", 32'(clk_on0), 32'd0);
    chk("mid_active0", active0, 32'd0);
    chk("mid_active4", active4, 32'd0);
    base0 = p0;
    rst = 1'b0; #1;  // released during the same high phase
    chk("mid_rel_gclk0", 32'(gclk0), 32'd0);
    @(negedge clk); #1;
    base4 = p4;
    chk("mid_low_gclk0", 32'(gclk0), 32'd0);
    @(posedge clk); #1;
    chk("mid_first_pulse", 32'(gclk0), 32'd1);
    chk("mid_first_clk_on", 32'(clk_on0), 32'd1);
    chk("mid_first_active", active0, 32'd1);
    chk("mid_pulse_count", 32'(p0 - base0), 32'd1);
    en0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_hold_gone", 32'(p4 - base4), 32'd0);
    chk("mid_active4_after", active4, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
